// File: rtl/axi_tdd_pkg.sv
// Shared TDD types and helpers.
// Used by the TDD core and its output stages.
package axi_tdd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;

    localparam int TDD_MAX_WIN = 4;
    localparam int TDD_MAX_CH  = 32;

    // Flattened slice index of window w of channel c.
    function automatic int window_idx(
        input int c,
        input int w,
        input int num_win
    );
        return c * num_win + w;
    endfunction

endpackage

// File: rtl/axi_tdd_channel_bank_ch.sv
// One TDD output channel: shadow config, frame-skip
// counter, window comparators and output flop.
module axi_tdd_channel_bank_ch
    import axi_tdd_pkg::*;
#(
    parameter int   NUM_WIN        = 2,
    parameter int   REGISTER_WIDTH = 32,
    parameter int   PERIOD_WIDTH   = 8,
    parameter logic RST_VAL        = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REGISTER_WIDTH-1:0]         tdd_counter,
    input  state_t                            tdd_cstate,
    input  logic                              tdd_enable,
    input  logic                              tdd_endof_frame,
    input  logic                              asy_ch_en,
    input  logic                              asy_ch_pol,
    input  logic [PERIOD_WIDTH-1:0]           asy_ch_period,
    input  logic [NUM_WIN*REGISTER_WIDTH-1:0] asy_t_high,
    input  logic [NUM_WIN*REGISTER_WIDTH-1:0] asy_t_low,
    output logic                              out,
    output logic                              ch_active
);

    typedef logic [NUM_WIN-1:0][REGISTER_WIDTH-1:0] win_t;

    logic                    en_q, en_d;
    logic                    pol_q, pol_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    win_t                    t_high_q, t_high_d;
    win_t                    t_low_q, t_low_d;
    logic [PERIOD_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                    act_q, act_d;
    logic                    set_q, set_d;
    logic                    rst_s_q, rst_s_d;
    logic                    lvl_q, lvl_d;
    logic                    out_q, out_d;
    logic                    load;
    logic                    running;

    assign load = tdd_enable &&
                  (tdd_cstate == ARMED || tdd_endof_frame);
    assign running = (tdd_cstate == RUNNING);

    // Next-state: shadow load at frame boundaries, frame
    // skip bookkeeping, window strobes and output SR level.
    always_comb begin
        en_d     = en_q;
        pol_d    = pol_q;
        period_d = period_q;
        t_high_d = t_high_q;
        t_low_d  = t_low_q;
        fcnt_d   = fcnt_q;
        act_d    = act_q;
        set_d    = 1'b0;
        rst_s_d  = tdd_endof_frame;
        lvl_d    = lvl_q;

        if (load) begin
            en_d     = asy_ch_en;
            pol_d    = asy_ch_pol;
            period_d = asy_ch_period;
            t_high_d = asy_t_high;
            t_low_d  = asy_t_low;
        end

        case (tdd_cstate)
            IDLE: begin
                fcnt_d = '0;
                act_d  = 1'b0;
            end
            ARMED: begin
                fcnt_d = '0;
                act_d  = asy_ch_en;
            end
            default: begin
                if (tdd_endof_frame) begin
                    // Compare against the period of the
                    // frame that is ending.
                    fcnt_d = (fcnt_q == period_q) ? '0 :
                             fcnt_q + PERIOD_WIDTH'(1);
                    act_d  = en_d && (fcnt_d == '0);
                end
            end
        endcase

        for (int w = 0; w < NUM_WIN; w++) begin
            if (running && tdd_counter == t_high_q[w])
                set_d = 1'b1;
            if (running && tdd_counter == t_low_q[w])
                rst_s_d = 1'b1;
        end

        // Level relative to idle polarity; reset wins.
        if (!act_q || rst_s_q)
            lvl_d = 1'b0;
        else if (set_q)
            lvl_d = 1'b1;

        out_d = pol_q ^ lvl_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            pol_q    <= 1'b0;
            period_q <= '0;
            t_high_q <= '0;
            t_low_q  <= '0;
            fcnt_q   <= '0;
            act_q    <= 1'b0;
            set_q    <= 1'b0;
            rst_s_q  <= 1'b0;
            lvl_q    <= 1'b0;
            out_q    <= RST_VAL;
        end else begin
            en_q     <= en_d;
            pol_q    <= pol_d;
            period_q <= period_d;
            t_high_q <= t_high_d;
            t_low_q  <= t_low_d;
            fcnt_q   <= fcnt_d;
            act_q    <= act_d;
            set_q    <= set_d;
            rst_s_q  <= rst_s_d;
            lvl_q    <= lvl_d;
            out_q    <= out_d;
        end
    end

    assign out       = out_q;
    assign ch_active = act_q;

endmodule

// File: rtl/axi_tdd_channel_bank.sv
// Multi-channel, multi-window TDD output bank.
// Slices the config buses into per-channel instances.
module axi_tdd_channel_bank
    import axi_tdd_pkg::*;
#(
    parameter int                NUM_CH           = 8,
    parameter int                NUM_WIN          = 2,
    parameter int                REGISTER_WIDTH   = 32,
    parameter int                PERIOD_WIDTH     = 8,
    parameter logic [NUM_CH-1:0] DEFAULT_POLARITY = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [REGISTER_WIDTH-1:0]                tdd_counter,
    input  axi_tdd_pkg::state_t                      tdd_cstate,
    input  logic                                     tdd_enable,
    input  logic                                     tdd_endof_frame,
    input  logic [NUM_CH-1:0]                        asy_ch_en,
    input  logic [NUM_CH-1:0]                        asy_ch_pol,
    input  logic [NUM_CH*PERIOD_WIDTH-1:0]           asy_ch_period,
    input  logic [NUM_CH*NUM_WIN*REGISTER_WIDTH-1:0] asy_t_high,
    input  logic [NUM_CH*NUM_WIN*REGISTER_WIDTH-1:0] asy_t_low,
    output logic [NUM_CH-1:0]                        out,
    output logic [NUM_CH-1:0]                        ch_active
);

    localparam int WB = NUM_WIN * REGISTER_WIDTH;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int WO = window_idx(c, 0, NUM_WIN) * REGISTER_WIDTH;

        axi_tdd_channel_bank_ch #(
            .NUM_WIN        (NUM_WIN),
            .REGISTER_WIDTH (REGISTER_WIDTH),
            .PERIOD_WIDTH   (PERIOD_WIDTH),
            .RST_VAL        (DEFAULT_POLARITY[c])
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .tdd_counter     (tdd_counter),
            .tdd_cstate      (tdd_cstate),
            .tdd_enable      (tdd_enable),
            .tdd_endof_frame (tdd_endof_frame),
            .asy_ch_en       (asy_ch_en[c]),
            .asy_ch_pol      (asy_ch_pol[c]),
            .asy_ch_period   (asy_ch_period[c*PERIOD_WIDTH +: PERIOD_WIDTH]),
            .asy_t_high      (asy_t_high[WO +: WB]),
            .asy_t_low       (asy_t_low[WO +: WB]),
            .out             (out[c]),
            .ch_active       (ch_active[c])
        );
    end

endmodule

// File: doc/axi_tdd_channel_bank.md
Name: axi_tdd_channel_bank

Overview:
Multi-channel, multi-window successor to the single-channel TDD output generator. It drives NUM_CH TDD control outputs from the shared TDD frame counter and state. Each channel has NUM_WIN independent on/off windows per frame, its own polarity, and a per-channel frame-skip divider. It sits between the axi_tdd counter/state machine and the pad-level TDD signals (TX/RX enables, switch controls).

Parameters:
NUM_CH, 8, number of output channels (1..32)
NUM_WIN, 2, on/off windows per channel (1..4)
REGISTER_WIDTH, 32, width of tdd_counter and of window timing values
PERIOD_WIDTH, 8, width of the per-channel frame-skip period
DEFAULT_POLARITY, {NUM_CH{1'b0}}, NUM_CH-bit value driven on out while reset is asserted

Ports:
clk  in  1  single clock for the whole block
rst  in  1  synchronous reset, active-high
tdd_counter  in  REGISTER_WIDTH  current frame counter
tdd_cstate  in  axi_tdd_pkg::state_t  TDD state: IDLE, ARMED, WAITING or RUNNING
tdd_enable  in  1  TDD core enabled
tdd_endof_frame  in  1  single-cycle end-of-frame strobe
asy_ch_en  in  NUM_CH  per-channel enable, async register domain, quasi-static
asy_ch_pol  in  NUM_CH  per-channel idle polarity
asy_ch_period  in  NUM_CH*PERIOD_WIDTH  per-channel frame period minus 1; channel i uses bits [i*PW +: PW]
asy_t_high  in  NUM_CH*NUM_WIN*REGISTER_WIDTH  window set times; channel c, window w at index (c*NUM_WIN+w)
asy_t_low  in  NUM_CH*NUM_WIN*REGISTER_WIDTH  window reset times, same indexing as asy_t_high
out  out  NUM_CH  TDD channel outputs
ch_active  out  NUM_CH  1 = channel is armed for the current frame (status/debug)

Behaviour:
- Reset (rst=1 at a clk edge) clears all internal state:
  - out <= DEFAULT_POLARITY; ch_active <= 0.
  - Shadow registers, frame counters, and set/reset strobes <= 0.
- Shadow config (ch_en, ch_pol, period, t_high, t_low):
  - Loaded only when tdd_enable=1 and (tdd_cstate==ARMED or tdd_endof_frame=1).
  - Otherwise held. Config therefore changes only at frame boundaries, never mid-frame.
- Per-channel frame counter fcnt (PERIOD_WIDTH bits):
  - IDLE: fcnt <= 0.
  - ARMED: fcnt <= 0.
  - On tdd_endof_frame: fcnt <= (fcnt == period) ? 0 : fcnt+1. Compare uses the shadow period in effect before the boundary. The newly loaded period applies from the next boundary.
- ch_active[i]:
  - IDLE: 0.
  - ARMED: asy_ch_en[i].
  - On tdd_endof_frame: ch_en_next[i] && (fcnt_next == 0).
  - Otherwise hold.
  - period=0 means every frame; period=P means frames 0, P+1, 2(P+1), ...
- Stage 1 (registered), per channel:
  - set_s = OR over w of (cstate==RUNNING && tdd_counter==t_high[w]).
  - rst_s = OR over w of (cstate==RUNNING && tdd_counter==t_low[w]), OR tdd_endof_frame.
- Stage 2, out[i]:
  - if !ch_active[i] or rst_s: out <= ch_pol[i].
  - else if set_s: out <= ~ch_pol[i].
  - else hold.
- Latency: counter match -> out change = 2 clk cycles.
- Reset beats set. A coincident set and reset from any windows, including t_high==t_low in one window, yields no pulse.
- Overlapping windows behave as one SR flop: the first set asserts, the first reset deasserts.
- Window values >= frame length never match; that window is inert.
- Leaving RUNNING (to IDLE) forces ch_active=0, so out returns to ch_pol within 2 cycles.
- rst asserted mid-frame gives immediate DEFAULT_POLARITY on the next edge. After release, out = ch_pol until the next ARMED.
- Widths: all compares are exact REGISTER_WIDTH equality; no arithmetic on timing values.

Decomposition:
- axi_tdd_pkg (existing): reuse state_t.
  - Add localparam TDD_MAX_WIN = 4.
  - Add localparam TDD_MAX_CH = 32.
  - Add a function window_idx(c, w, num_win) returning the flattened slice index.
- One sub-module, axi_tdd_channel_bank_ch: holds one channel's shadow registers, fcnt, NUM_WIN comparators, stage-1 strobes and output flop. It is instantiated NUM_CH times in a generate loop. The top level only slices buses.

Test Plan:
- Reset: DEFAULT_POLARITY=8'hA5, rst pulse -> out==8'hA5, ch_active==0. After release with IDLE -> out==ch_pol.
- Single window: NUM_WIN=2, ch0 en, pol=0, t_high[0]=10, t_low[0]=20, window 1 = 0xFFFFFFFF, frame length 100, RUNNING -> out[0] rises when counter==12 and falls when counter==22, every frame.
- Dual window: ch1 windows (10,20) and (50,70) -> two pulses per frame, high on counter 12..21 and 52..71. Repeat with pol=1 -> inverted waveform.
- Collision: t_high[0]=30, t_low[1]=30 -> no pulse at 30. Separately t_high=t_low=40 -> out stays ch_pol.
- Frame skip: ch2 period=2 -> pulses in frames 0, 3, 6 only; ch_active[2] toggles at each endof_frame accordingly. Change period to 0 mid-run -> takes effect at the next boundary, not mid-frame.
- Mid-frame abort and config: change asy_t_high during a frame -> no effect until the next endof_frame. Force cstate to IDLE while out is active -> out==ch_pol within 2 cycles. Assert rst while out is active -> out==DEFAULT_POLARITY the next cycle.
